// File: rtl/uart_prog_pkg.sv
// Shared types and elaboration helpers for the UART program loader.
package uart_prog_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_WAIT,
    LD_LOAD,
    LD_DONE
  } ld_state_t;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Width of a down-counter that is loaded with (clks - 1).
  function automatic int calc_timer_width(input int clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, start-bit qualification, 8N1 framing.
//
// state    | meaning
// RX_IDLE  | line idle, watching for a falling edge
// RX_START | waiting half a bit to confirm the start bit
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling the stop bit
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       start_det,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  rx_state_t        next_state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick;
  logic             fall;

  always_ff @(posedge clock) begin
    if (reset) state <= RX_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (fall) next_state = RX_START;
      RX_START: if (tick) next_state = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (tick) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  always_comb begin
    tick      = (cnt == '0);
    fall      = rx_prev & ~rx_sync;
    start_det = (state == RX_IDLE) && fall;
  end

  // Counter is preloaded with the half-bit value while idle so the
  // start-bit check lands mid-bit without an extra load cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= HALF_LOAD;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      stop_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= HALF_LOAD;
          bit_idx <= 3'd0;
        end
        RX_START: begin
          if (tick) cnt <= FULL_LOAD;
          else      cnt <= cnt - CNT_W'(1);
        end
        RX_DATA: begin
          if (tick) begin
            cnt     <= FULL_LOAD;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: cnt <= HALF_LOAD;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: assembles big-endian words from UART bytes, writes them
// to instruction memory and holds the CPU in reset while a session is active.
//
// state   | meaning
// LD_WAIT | idle, CPU running, waiting for a start_pg rising edge
// LD_LOAD | CPU held, bytes assembled into words and written
// LD_DONE | one-cycle session end, prog_done pulses
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int CLK_HZ    = 23_000_000,
  parameter int BAUD      = 128_000,
  parameter int ADDR_W    = 14,
  parameter int IDLE_BITS = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              rx,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wdata,
  output logic              cpu_hold,
  output logic              prog_done,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int IDLE_CLKS    = IDLE_BITS * CLKS_PER_BIT;
  localparam int TMR_W        = calc_timer_width(IDLE_CLKS);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(IDLE_CLKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic              start_det;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              stop_err;

  ld_state_t         state;
  ld_state_t         next_state;
  logic              start_prev;
  logic              start_rise;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   wcnt;
  logic [1:0]        byte_cnt;
  logic [1:0]        cnt_after;
  logic [23:0]       asm_sh;
  logic              armed;
  logic [TMR_W-1:0]  tmr;
  logic              timeout;
  logic              take;
  logic              word_done;
  logic              leaving;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .start_det (start_det),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .stop_err  (stop_err)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= LD_WAIT;
    else       state <= next_state;
  end

  always_comb begin
    start_rise = start_pg & ~start_prev;
    timeout    = (tmr == '0);
    take       = (state == LD_LOAD) && armed && byte_valid;
    word_done  = take && (byte_cnt == 2'd3);
    cnt_after  = take ? byte_cnt + 2'd1 : byte_cnt;
    next_state = state;
    case (state)
      LD_WAIT: if (start_rise) next_state = LD_LOAD;
      LD_LOAD: begin
        if (!start_pg || (word_done && addr == LAST_ADDR) || (timeout && wcnt != '0))
          next_state = LD_DONE;
      end
      LD_DONE: next_state = LD_WAIT;
      default: next_state = LD_WAIT;
    endcase
  end

  always_comb begin
    cpu_hold  = (state == LD_LOAD);
    prog_done = (state == LD_DONE);
    leaving   = (state == LD_LOAD) && (next_state == LD_DONE);
  end

  // armed is set only by a start bit seen inside the session, so a byte already
  // in flight when start_pg rises is dropped and loading begins with the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_prev <= 1'b0;
      addr       <= '0;
      wcnt       <= '0;
      byte_cnt   <= 2'd0;
      asm_sh     <= 24'h0;
      armed      <= 1'b0;
      tmr        <= TMR_LOAD;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= 32'h0;
      frame_err  <= 1'b0;
      word_count <= '0;
    end else begin
      start_prev <= start_pg;
      prog_we    <= 1'b0;
      if (state == LD_WAIT && start_rise) begin
        addr       <= '0;
        wcnt       <= '0;
        byte_cnt   <= 2'd0;
        word_count <= '0;
        frame_err  <= 1'b0;
        armed      <= 1'b0;
        tmr        <= TMR_LOAD;
      end
      if (state == LD_LOAD) begin
        if (start_det) begin
          tmr   <= TMR_LOAD;
          armed <= 1'b1;
        end else if (!timeout) begin
          tmr <= tmr - TMR_W'(1);
        end
        if (take) begin
          byte_cnt <= cnt_after;
          asm_sh   <= {asm_sh[15:0], byte_data};
        end
        if (word_done) begin
          prog_we    <= 1'b1;
          prog_addr  <= addr;
          prog_wdata <= {asm_sh, byte_data};
          addr       <= addr + ADDR_W'(1);
          wcnt       <= wcnt + {{ADDR_W{1'b0}}, 1'b1};
        end
        if (armed && stop_err) frame_err <= 1'b1;
        if (leaving) begin
          word_count <= wcnt + {{ADDR_W{1'b0}}, word_done};
          if (cnt_after != 2'd0) frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed sessions with random payloads, checked against a byte-queue model
// of the loader (good bytes grouped four at a time, big-endian, from address 0).
module tb_uart_prog_loader;

  localparam int CLK_HZ    = 1_000_000;
  localparam int BAUD      = 100_000;
  localparam int ADDR_W    = 14;
  localparam int IDLE_BITS = 40;
  localparam int CPB       = CLK_HZ / BAUD;

  logic              clock    = 1'b0;
  logic              reset    = 1'b1;
  logic              start_pg = 1'b0;
  logic              rx       = 1'b1;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_wdata;
  logic              cpu_hold;
  logic              prog_done;
  logic              frame_err;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [7:0]        sent_q[$];
  bit                good_q[$];

  always #5 clock = ~clock;

  uart_prog_loader #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .ADDR_W   (ADDR_W),
    .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start_pg  (start_pg),
    .rx        (rx),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata),
    .cpu_hold  (cpu_hold),
    .prog_done (prog_done),
    .frame_err (frame_err),
    .word_count(word_count)
  );

  always @(negedge clock) begin
    if (prog_we === 1'b1) begin
      wa_q.push_back(prog_addr);
      wd_q.push_back(prog_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_queues();
    wa_q.delete();
    wd_q.delete();
    sent_q.delete();
    good_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = good;
    tick(CPB);
    if (!good) begin
      rx = 1'b1;
      tick(2 * CPB);
    end
    sent_q.push_back(b);
    good_q.push_back(good);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic begin_session(input string tag);
    clear_queues();
    start_pg = 1'b1;
    @(negedge clock);
    chk({tag, ".hold_before_edge"}, 64'(cpu_hold), 64'd0);
    @(negedge clock);
    chk({tag, ".hold_after_edge"}, 64'(cpu_hold), 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic end_session(input string tag);
    logic [7:0] acc[$];
    bit         exp_ferr;
    int         nw;
    int         n;
    bit         seen;
    exp_ferr = 1'b0;
    foreach (sent_q[i]) begin
      if (good_q[i]) acc.push_back(sent_q[i]);
      else           exp_ferr = 1'b1;
    end
    nw = acc.size() / 4;
    if (acc.size() % 4 != 0) exp_ferr = 1'b1;

    n    = 0;
    seen = 1'b0;
    while (!seen && n < 800) begin
      @(negedge clock);
      n++;
      if (prog_done === 1'b1) seen = 1'b1;
    end
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, ".hold_at_done"}, 64'(cpu_hold), 64'd0);
      chk({tag, ".word_count"}, 64'(word_count), 64'(nw));
      chk({tag, ".frame_err"}, 64'(frame_err), 64'(exp_ferr));
      // Timer restarts at the last start bit: 400 clocks minus the 100 spent on
      // that byte, plus a few cycles of synchronizer latency.
      chk({tag, ".idle_latency"}, 64'(n >= 290 && n <= 320), 64'd1);
      @(negedge clock);
      chk({tag, ".done_one_cycle"}, 64'(prog_done), 64'd0);
      chk({tag, ".word_count_held"}, 64'(word_count), 64'(nw));
    end
    chk({tag, ".write_count"}, 64'(wa_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 64'(wa_q[i]), 64'(i));
      chk($sformatf("%s.data%0d", tag, i), 64'(wd_q[i]),
          64'({acc[4*i], acc[4*i+1], acc[4*i+2], acc[4*i+3]}));
    end
    if (nw > 0) chk({tag, ".addr_held"}, 64'(prog_addr), 64'(nw - 1));
    @(posedge clock);
    #1;
    start_pg = 1'b0;
    tick(3);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".prog_we"}, 64'(prog_we), 64'd0);
    chk({tag, ".prog_addr"}, 64'(prog_addr), 64'd0);
    chk({tag, ".prog_wdata"}, 64'(prog_wdata), 64'd0);
    chk({tag, ".cpu_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, ".prog_done"}, 64'(prog_done), 64'd0);
    chk({tag, ".frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, ".word_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    // Power-on reset
    tick(3);
    @(negedge clock);
    chk_reset_values("por");
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(5);

    // Single known word
    begin_session("word1");
    send_byte(8'h24, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    end_session("word1");

    // Three words back-to-back
    begin_session("word3");
    send_random(12);
    end_session("word3");

    // Bad stop bit on 0x55, then a good word
    begin_session("badstop");
    send_byte(8'h55, 1'b0);
    send_random(4);
    end_session("badstop");

    // Six bytes: one word plus two leftovers
    begin_session("partial");
    send_random(6);
    end_session("partial");

    // Short low glitch on rx must not produce a byte
    begin_session("glitch");
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * CPB);
    chk("glitch.no_write", 64'(wa_q.size()), 64'd0);
    send_random(4);
    end_session("glitch");

    // start_pg rises mid-byte: that byte is skipped
    clear_queues();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = 1'($urandom_range(0, 1));
      if (i == 4) start_pg = 1'b1;
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB);
    chk("midbyte.hold", 64'(cpu_hold), 64'd1);
    send_random(4);
    end_session("midbyte");

    // Reset after the 2nd byte of the 3rd word
    begin_session("abort");
    send_random(10);
    chk("abort.writes_before", 64'(wa_q.size()), 64'd2);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_reset_values("abort");
    chk("abort.no_extra_write", 64'(wa_q.size()), 64'd2);
    start_pg = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(3);
    begin_session("after_abort");
    send_random(4);
    end_session("after_abort");

    // Random word counts with optional leftover bytes
    for (int s = 0; s < 2; s++) begin
      begin_session($sformatf("rand%0d", s));
      send_random(4 * $urandom_range(1, 3) + $urandom_range(0, 1));
      end_session($sformatf("rand%0d", s));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
